// File: rtl/xs3_pkg.sv
// Shared types and constants for the binary to excess-3 sequencer.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit cell operation: conditional double-dabble fixup or unconditional bias.
  typedef enum logic {
    ADJ_DABBLE = 1'b0,
    ADJ_BIAS   = 1'b1
  } adj_mode_t;

  localparam logic [3:0] XS3_BIAS      = 4'd3;
  localparam logic [3:0] DABBLE_THRESH = 4'd5;

  // Decimal digits needed for a bin_w-bit unsigned value (log10(2) ~= 0.301).
  function automatic int min_digits(input int bin_w);
    return (bin_w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/xs3_digit_adj.sv
// One 4-bit digit adjust cell. Dabble mode adds 3 to digits >= 5 so the
// following left shift carries correctly into the next decade; bias mode
// adds 3 unconditionally to form the excess-3 code. No carry out.
module xs3_digit_adj
  import xs3_pkg::*;
(
  input  adj_mode_t  mode,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add the excess-3 constant when in bias mode or when the digit needs fixup.
  always_comb begin
    dout = din;
    if (mode == ADJ_BIAS || din >= DABBLE_THRESH) dout = din + XS3_BIAS;
  end

endmodule

// File: rtl/bin_to_xs3_seq.sv
// Sequential binary to packed excess-3 converter (double dabble, 1 bit/clk).
// Optional build macro XS3_BCD_OUT_EN adds the out_bcd port carrying the
// plain BCD result alongside out_xs3.
module bin_to_xs3_seq
  import xs3_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3
`ifdef XS3_BCD_OUT_EN
  ,
  output logic [4*DIGITS-1:0]   out_bcd
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_chk
    $error("bin_to_xs3_seq: DIGITS too small for BIN_W");
  end

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_bcd;
  logic [CNT_W-1:0] cnt_q;
  adj_mode_t        mode;
  logic             accept;
  logic             out_fire;
  logic             load_out;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // First DONE cycle: the digit cells are in bias mode, capture their result.
  assign load_out = (state_q == DONE) && !out_valid;

  // The same digit cells serve both the dabble step and the final bias step.
  assign mode = (state_q == DONE) ? ADJ_BIAS : ADJ_DABBLE;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    xs3_digit_adj u_adj (
      .mode (mode),
      .din  (bcd_q[4*d +: 4]),
      .dout (adj_bcd[4*d +: 4])
    );
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shift field and iteration counter: load on accept, dabble+shift in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      bin_q <= in_bin;
      bcd_q <= '0;
      cnt_q <= CNT_W'(BIN_W);
    end else if (state_q == SHIFT) begin
      {bcd_q, bin_q} <= {adj_bcd[BCD_W-2:0], bin_q, 1'b0};
      cnt_q          <= cnt_q - CNT_W'(1);
    end
  end

  // Output register: capture biased digits once, hold until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_xs3   <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_xs3   <= adj_bcd;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef XS3_BCD_OUT_EN
  // Plain BCD result, captured on the same cycle as out_xs3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out_bcd <= '0;
    else if (load_out) out_bcd <= bcd_q;
  end
`endif

endmodule

// File: tb/tb_bin_to_xs3_seq.sv
// Directed bench for bin_to_xs3_seq with a scoreboard of expected results.
// Define XS3_BCD_OUT_EN to also check the out_bcd port.
module tb_bin_to_xs3_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = BIN_W + 1;
  // accept, BIN_W shifts, bias capture, handshake edge, idle accept edge
  localparam int PERIOD = BIN_W + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_xs3;
`ifdef XS3_BCD_OUT_EN
  logic [W-1:0]     out_bcd;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc;
  logic [W-1:0] xq[$];
  logic [W-1:0] bq[$];

  bin_to_xs3_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3)
`ifdef XS3_BCD_OUT_EN
    ,
    .out_bcd   (out_bcd)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] bcd_ref(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] xs3_ref(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10 + 3);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive/check point: a little after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present v; once accepted optionally push the expected result.
  task automatic send(input int v, input bit track, input bit keep);
    int n;
    n = 0;
    in_bin   = BIN_W'(v);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    if (track) begin
      xq.push_back(xs3_ref(v));
      bq.push_back(bcd_ref(v));
    end
    tick();
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (xq.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", xq.size(), 0);
  endtask

  // Scoreboard: compare each output handshake against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_nonempty", {31'd0, xq.size() > 0}, 32'd1);
      if (xq.size() > 0) begin
        chk("xs3", out_xs3, xq.pop_front());
`ifdef XS3_BCD_OUT_EN
        chk("bcd", out_bcd, bq.pop_front());
`else
        void'(bq.pop_front());
`endif
      end
    end
  end

  initial begin
    int n;
    int prev;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_xs3", 32'(out_xs3), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Zero input and latency from accept to out_valid.
    out_ready = 1'b1;
    send(0, 1, 0);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("latency", cyc - acc_cyc, LAT);
    chk("zero_xs3", 32'(out_xs3), 32'h333);
    drain();

    // Full-scale and a few mixed patterns.
    send(255, 1, 0); drain();
    send(100, 1, 0); drain();
    send(9,   1, 0); drain();

    // Back-pressure: hold out_ready low, try to inject another word.
    out_ready = 1'b0;
    send(77, 1, 0);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_bin   = BIN_W'(5);
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_xs3", 32'(out_xs3), 32'h3AA);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    repeat (15) tick();
    chk("bp_no_extra", xq.size(), 0);

    // Reset in the middle of a conversion.
    send(200, 0, 0);
    repeat (4) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_xs3", 32'(out_xs3), 32'd0);
    tick();
    rst = 1'b0;
    repeat (15) tick();
    send(42, 1, 0);
    drain();

    // Back-to-back sweep with in_valid and out_ready held high.
    prev = 0;
    for (int v = 0; v < 256; v++) begin
      send(v, 1, 1);
      if (v > 0) chk("period", acc_cyc - prev, PERIOD);
      prev = acc_cyc;
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
